// File: rtl/visor_pkg.sv
// Shared types and constants for the result display back-end.
// Holds the FSM state enum, glyph constants, digit indices and conversion length.
package visor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_SIGN  = 2'd2;

    localparam logic [2:0] CONV_STEPS = 3'd5;

endpackage

// File: rtl/bcd_a_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder, order {g,f,e,d,c,b,a}.
// Ports: bcd (4-bit digit in), seg (7-bit glyph out); 10..15 decode to blank.
module bcd_a_7seg
    import visor_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/visor_resultado.sv
// Result display: accepts a sign-magnitude result, converts it to BCD by
// double-dabble and scans sign/tens/units onto a 3-digit common-anode display.
// Ports: clk, rst_n (sync, active-low), res_valid/res_ready handshake,
// op, res[4:0], neg inputs; an[2:0] anodes and seg[6:0] segments (active-low).
// Optional: define LEADING_ZERO_BLANK_EN to blank the tens digit when it is 0.
module visor_resultado
    import visor_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic       op,
    input  logic [4:0] res,
    input  logic       neg,
    output logic [2:0] an,
    output logic [6:0] seg
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t     state;
    logic [2:0] iter;
    logic [7:0] bcd;
    logic [4:0] val;
    logic       cap_sign;

    logic [3:0] tens;
    logic [3:0] units;
    logic       sign;

    logic [7:0] bcd_adj;
    logic [7:0] bcd_nx;
    logic [4:0] val_nx;

    assign res_ready = (state == IDLE);

    // One double-dabble iteration: correct nibbles, then shift {bcd, val}.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        {bcd_nx, val_nx} = {bcd_adj[6:0], val, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            iter     <= 3'd0;
            bcd      <= 8'd0;
            val      <= 5'd0;
            cap_sign <= 1'b0;
            tens     <= 4'd0;
            units    <= 4'd0;
            sign     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        val      <= op ? {1'b0, res[3:0]} : res;
                        cap_sign <= op & neg;
                        bcd      <= 8'd0;
                        iter     <= 3'd0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd  <= bcd_nx;
                    val  <= val_nx;
                    iter <= iter + 3'd1;
                    if (iter == CONV_STEPS - 3'd1) begin
                        tens  <= bcd_nx[7:4];
                        units <= bcd_nx[3:0];
                        sign  <= cap_sign;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [6:0] seg_units;
    logic [6:0] seg_tens_raw;
    logic [6:0] seg_tens;

    bcd_a_7seg u_dec_units (
        .bcd (units),
        .seg (seg_units)
    );

    bcd_a_7seg u_dec_tens (
        .bcd (tens),
        .seg (seg_tens_raw)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign seg_tens = (tens == 4'd0) ? SEG_BLANK : seg_tens_raw;
`else
    assign seg_tens = seg_tens_raw;
`endif

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [2:0]    an_mux;
    logic [6:0]    seg_mux;

    always_comb begin
        an_mux  = 3'b111;
        seg_mux = SEG_BLANK;
        case (dig)
            DIG_UNITS: begin
                an_mux  = 3'b110;
                seg_mux = seg_units;
            end
            DIG_TENS: begin
                an_mux  = 3'b101;
                seg_mux = seg_tens;
            end
            DIG_SIGN: begin
                an_mux  = 3'b011;
                seg_mux = sign ? SEG_MINUS : SEG_BLANK;
            end
            default: begin
                an_mux  = 3'b111;
                seg_mux = SEG_BLANK;
            end
        endcase
    end

    // Scan runs independently of the converter; outputs lag dig by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            dig <= DIG_UNITS;
            an  <= 3'b111;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_mux;
            seg <= seg_mux;
            if (cnt == CW'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                dig <= (dig == DIG_SIGN) ? DIG_UNITS : dig + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
